// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch / load-store memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Memory-wait watchdog: counts stalled BUSY cycles and flags the last allowed one.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clk, rst_n, clear, enable};
            assign expired_c = 1'b0;
        end else begin : g_on
            localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] count;

            // Saturating counter, cleared while the arbiter is idle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (enable && (count != '1)) begin
                    count <= count + CNT_W'(1);
                end
            end

            assign expired_c = enable && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported memory bus between instruction fetch and load/store.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [STRB_W-1:0] d_wstrb,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e state;
    arb_state_e state_next;
    grant_e     last_grant;
    logic       wd_clear;
    logic       wd_enable;
    logic       wd_expired_c;

    assign wd_clear  = (state == IDLE);
    assign wd_enable = (state != IDLE) && !mem_ack;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (wd_clear),
        .enable    (wd_enable),
        .expired_c (wd_expired_c)
    );

    // State, grant history and captured request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= GRANT_I;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            state   <= state_next;
            mem_req <= (state_next != IDLE);
            if (state == IDLE) begin
                if (state_next == BUSY_D) begin
                    last_grant <= GRANT_D;
                    mem_we     <= d_we;
                    mem_addr   <= d_addr;
                    mem_wdata  <= d_wdata;
                    mem_wstrb  <= d_wstrb;
                end else if (state_next == BUSY_I) begin
                    last_grant <= GRANT_I;
                    mem_we     <= 1'b0;
                    mem_addr   <= i_addr;
                    mem_wdata  <= '0;
                    mem_wstrb  <= '0;
                end
            end
        end
    end

    // Next state and response routing; memory ack beats a same-cycle timeout.
    always_comb begin
        state_next = state;
        i_ack      = 1'b0;
        i_err      = 1'b0;
        i_rdata    = '0;
        d_ack      = 1'b0;
        d_err      = 1'b0;
        d_rdata    = '0;

        unique case (state)
            IDLE: begin
                if (d_req && (!i_req || (last_grant == GRANT_I))) begin
                    state_next = BUSY_D;
                end else if (i_req) begin
                    state_next = BUSY_I;
                end
            end
            BUSY_I: begin
                if (mem_ack) begin
                    i_ack      = 1'b1;
                    i_rdata    = mem_rdata;
                    state_next = IDLE;
                end else if (wd_expired_c) begin
                    i_ack      = 1'b1;
                    i_err      = 1'b1;
                    state_next = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    d_ack      = 1'b1;
                    d_rdata    = mem_rdata;
                    state_next = IDLE;
                end else if (wd_expired_c) begin
                    d_ack      = 1'b1;
                    d_err      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (watchdog set to 4 cycles).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(
        .TIMEOUT_CYCLES (4),
        .ADDR_W         (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        // State straight out of reset.
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
        checks++; if ({i_ack, d_ack, i_err, d_err} !== 4'b0) begin failures++; $display("FAIL rst_acks got=%b exp=0000", {i_ack, d_ack, i_err, d_err}); end
        // Reset asserted in the middle of a data transaction.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1; d_wstrb = 4'h3;
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_busy_mem_req got=%b exp=1", mem_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_async_mem_req got=%b exp=0", mem_req); end
        checks++; if ({i_ack, d_ack} !== 2'b00) begin failures++; $display("FAIL rst_async_acks got=%b exp=00", {i_ack, d_ack}); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL rst_async_mem_addr got=%h exp=0", mem_addr); end
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            checks++; if ({mem_req, i_ack, d_ack} !== 3'b000) begin failures++; $display("FAIL rst_after got=%b exp=000", {mem_req, i_ack, d_ack}); end
        end
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0040; #1;
        checks++; if (i_ack !== 1'b0) begin failures++; $display("FAIL fetch_idle_ack got=%b exp=0", i_ack); end
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin failures++; $display("FAIL fetch_bus got req=%b addr=%h we=%b exp req=1 addr=40 we=0", mem_req, mem_addr, mem_we); end
        checks++; if (i_ack !== 1'b0) begin failures++; $display("FAIL fetch_wait_ack got=%b exp=0", i_ack); end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h0010_0093; #1;
        checks++; if (i_ack !== 1'b1 || i_rdata !== 32'h0010_0093 || i_err !== 1'b0) begin failures++; $display("FAIL fetch_ack got ack=%b rdata=%h err=%b exp ack=1 rdata=00100093 err=0", i_ack, i_rdata, i_err); end
        checks++; if (d_ack !== 1'b0 || d_rdata !== 32'h0) begin failures++; $display("FAIL fetch_other got d_ack=%b d_rdata=%h exp 0/0", d_ack, d_rdata); end
        @(negedge clk);
        i_req = 1'b0; mem_ack = 1'b0; #1;
        checks++; if (i_ack !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL fetch_done got ack=%b req=%b exp 0/0", i_ack, mem_req); end
    endtask

    task automatic test_store();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678; #1;
        checks++; if (d_ack !== 1'b0) begin failures++; $display("FAIL store_idle_ack got=%b exp=0", d_ack); end
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'hF)
            begin failures++; $display("FAIL store_bus got req=%b we=%b addr=%h wdata=%h wstrb=%h exp 1/1/100/deadbeef/f", mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb); end
        checks++; if (d_ack !== 1'b1 || d_err !== 1'b0 || i_ack !== 1'b0) begin failures++; $display("FAIL store_ack got d_ack=%b d_err=%b i_ack=%b exp 1/0/0", d_ack, d_err, i_ack); end
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0; #1;
        checks++; if (mem_req !== 1'b0 || i_ack !== 1'b0) begin failures++; $display("FAIL store_done got req=%b i_ack=%b exp 0/0", mem_req, i_ack); end
    endtask

    task automatic test_contention();
        logic exp_d;
        logic exp_i;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                i_req = 1'b1; i_addr = 32'h80;
                d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
                mem_ack = 1'b1; mem_rdata = 32'hA5A5_0000;
            end
            #1;
            exp_d = (k % 4 == 1);
            exp_i = (k % 4 == 3);
            checks++; if (d_ack !== exp_d || i_ack !== exp_i) begin failures++; $display("FAIL contend_k%0d got d_ack=%b i_ack=%b exp %b/%b", k, d_ack, i_ack, exp_d, exp_i); end
            if (exp_d) begin
                checks++; if (mem_addr !== 32'h300 || d_rdata !== 32'hA5A5_0000) begin failures++; $display("FAIL contend_d_k%0d got addr=%h rdata=%h exp 300/a5a50000", k, mem_addr, d_rdata); end
            end
            if (exp_i) begin
                checks++; if (mem_addr !== 32'h80 || i_rdata !== 32'hA5A5_0000) begin failures++; $display("FAIL contend_i_k%0d got addr=%h rdata=%h exp 80/a5a50000", k, mem_addr, i_rdata); end
            end
        end
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                i_req = 1'b1; i_addr = 32'h1000 + 32'(4 * (k / 2));
                mem_ack = 1'b1; mem_rdata = 32'h5000 + 32'(k);
            end
            #1;
            checks++; if (i_ack !== (k % 2 == 1)) begin failures++; $display("FAIL b2b_ack_k%0d got=%b exp=%b", k, i_ack, (k % 2 == 1)); end
            if (k % 2 == 1) begin
                checks++; if (mem_addr !== 32'h1000 + 32'(4 * (k / 2))) begin failures++; $display("FAIL b2b_addr_k%0d got=%h exp=%h", k, mem_addr, 32'h1000 + 32'(4 * (k / 2))); end
            end
        end
        @(negedge clk);
        i_req = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_timeout();
        for (int run = 0; run < 2; run++) begin
            @(negedge clk);
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
            mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                if (c == 4 && run == 1) mem_ack = 1'b1;
                #1;
                if (c < 4) begin
                    checks++; if (d_ack !== 1'b0 || mem_req !== 1'b1) begin failures++; $display("FAIL tmo_wait_r%0d_c%0d got ack=%b req=%b exp 0/1", run, c, d_ack, mem_req); end
                end else if (run == 0) begin
                    checks++; if (d_ack !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin failures++; $display("FAIL tmo_expire got ack=%b err=%b rdata=%h exp 1/1/0", d_ack, d_err, d_rdata); end
                end else begin
                    checks++; if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL tmo_ack_wins got ack=%b err=%b rdata=%h exp 1/0/ffffffff", d_ack, d_err, d_rdata); end
                end
                checks++; if (i_ack !== 1'b0) begin failures++; $display("FAIL tmo_i_ack_r%0d_c%0d got=%b exp=0", run, c, i_ack); end
            end
            @(negedge clk);
            d_req = 1'b0; mem_ack = 1'b0; #1;
            checks++; if (mem_req !== 1'b0 || d_ack !== 1'b0) begin failures++; $display("FAIL tmo_idle_r%0d got req=%b ack=%b exp 0/0", run, mem_req, d_ack); end
        end
    endtask

    task automatic test_stray_ack();
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777; #1;
        checks++; if ({i_ack, d_ack, i_rdata != 32'h0, d_rdata != 32'h0} !== 4'b0) begin failures++; $display("FAIL stray_ack got i=%b d=%b irdata=%h drdata=%h exp all 0", i_ack, d_ack, i_rdata, d_rdata); end
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin failures++; $display("FAIL stray_idle got req=%b i=%b d=%b exp 000", mem_req, i_ack, d_ack); end
        @(negedge clk);
        mem_ack = 1'b0; i_req = 1'b1; i_addr = 32'h44;
        @(negedge clk);
        i_addr = 32'h999; #1;
        checks++; if (mem_addr !== 32'h44 || mem_req !== 1'b1 || i_ack !== 1'b0) begin failures++; $display("FAIL hold_addr got addr=%h req=%b ack=%b exp 44/1/0", mem_addr, mem_req, i_ack); end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h13; #1;
        checks++; if (i_ack !== 1'b1 || i_rdata !== 32'h13 || mem_addr !== 32'h44) begin failures++; $display("FAIL hold_ack got ack=%b rdata=%h addr=%h exp 1/13/44", i_ack, i_rdata, mem_addr); end
        @(negedge clk);
        i_req = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_single_fetch();
        test_store();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_stray_ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported memory bus between the instruction-fetch path and the load/store path of the rv32i core. Accepts one transaction at a time, registers the winner's request, drives the memory bus until the memory acknowledges, and routes the response back to the winner. A watchdog aborts transactions the memory never acknowledges. Sits between the core and the unified RAM model.

## Interface
- TIMEOUT_CYCLES, 255: memory-wait cycles before abort; 0 disables the watchdog.
- ADDR_W, 32: address width.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr until i_ack.
- i_addr  in  ADDR_W  fetch address.
- i_ack  out  1  fetch done; i_rdata valid this cycle.
- i_rdata  out  32  fetch data.
- i_err  out  1  qualifies i_ack: transaction timed out.
- d_req  in  1  load/store request; held with all d_* inputs until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  32  store data.
- d_wstrb  in  4  byte enables for stores.
- d_ack  out  1  data done; d_rdata valid on loads.
- d_rdata  out  32  load data.
- d_err  out  1  qualifies d_ack: transaction timed out.
- mem_req  out  1  memory transaction pending.
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/32/4  registered copy of the granted request.
- mem_ack  in  1  memory done; mem_rdata valid this cycle.
- mem_rdata  in  32  memory read data.

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: samples requests each cycle. Only i_req → BUSY_I; only d_req → BUSY_D; both → data wins unless last_grant = D, then fetch wins (alternation, no starvation). On transition, capture the winner's addr/we/wdata/wstrb into mem_* registers and record last_grant. Fetch captures mem_we = 0, mem_wstrb = 0.
- BUSY_x: mem_req = 1. On mem_ack: x_ack = 1, x_rdata = mem_rdata (combinational pass-through), x_err = 0, next state IDLE.
- Watchdog: counter cleared on entering BUSY, increments each BUSY cycle without mem_ack. When count reaches TIMEOUT_CYCLES-1 with no mem_ack: x_ack = 1, x_err = 1, x_rdata = 0, next state IDLE. mem_ack on that same cycle wins (normal completion, err = 0).
- mem_ack in IDLE is ignored; no ack is generated.
- Non-granted requester sees ack = 0, err = 0, rdata = 0.
- A requester must deassert req the cycle after its ack unless issuing a new request; req high in IDLE is always treated as new.
- Request inputs are sampled only in IDLE; changes during BUSY have no effect.

## Timing
- Reset (asynchronous, immediate): state IDLE, mem_req 0, all mem_* 0, all acks/errs 0, rdata 0, counter 0, last_grant = I (so first contention grants data).
- Reset mid-transaction drops mem_req at once; the in-flight transaction is abandoned without ack.
- Request seen in IDLE at cycle N → mem_req high at N+1. mem_ack at cycle M ≥ N+1 → x_ack at M → IDLE at M+1.
- Zero-wait memory: 2 cycles per transfer; back-to-back requests from one requester complete every 2 cycles.
- Timeout with TIMEOUT_CYCLES = T: ack/err in the T-th BUSY cycle (N+T).
- Counter width = $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.

## Structure
- Package mem_arb_pkg: state enum (IDLE, BUSY_I, BUSY_D), grant enum (GRANT_I, GRANT_D).
- Sub-module mem_arb_watchdog: clear/enable inputs, expired output, parameterised by TIMEOUT_CYCLES; tied off when TIMEOUT_CYCLES = 0.
- Everything else in one always_ff for state/capture registers and one always_comb for outputs/next state.

## Test plan
- Reset: rst_n low mid-BUSY_D → mem_req, d_ack, i_ack 0 same cycle; after release, state IDLE, no spurious ack.
- Single fetch: i_req, i_addr = 0x0000_0040, mem_ack one cycle after mem_req with rdata 0x0010_0093 → mem_addr 0x40, mem_we 0, i_ack with i_rdata 0x0010_0093, i_err 0, exactly one ack.
- Store: d_req, d_we = 1, d_addr 0x100, d_wdata 0xDEAD_BEEF, d_wstrb 0xF, zero-wait mem → mem_* match, d_ack at N+1, i_ack never.
- Contention: i_req and d_req held continuously, zero-wait mem → grants alternate D, I, D, I starting with D; one transfer per 2 cycles.
- Timeout: TIMEOUT_CYCLES = 4, mem_ack never → d_ack with d_err = 1, d_rdata 0 at N+4; IDLE at N+5; with mem_ack at N+4 instead → d_err = 0.
- Stray mem_ack in IDLE and i_addr change during BUSY_I → no ack; mem_addr keeps the captured value.
